instr_fetch_unit: RTL

- Sequential fetch stage of the single-cycle RISC-V core; sits directly upstream of the control/decode block.
- Owns the PC register and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Holds the fetched instruction stable for decode until the core pulses commit.
- On commit, computes the next PC from the control block's pcSel plus execute-stage operands.

---
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register and instruction fetch FSM for the single-cycle core
// Optional macro FETCH_TIMEOUT_EN adds a fetch watchdog driving the sticky fetch_err flag.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int              TIMEOUT_CYCLES = 255
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            im_req,
    output logic [XLEN-1:0] im_addr,
    input  logic            im_gnt,
    input  logic            im_rvalid,
    input  logic [31:0]     im_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            commit,
    input  logic [2:0]      pcSel,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            misaligned,
    output logic            fetch_err
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT_RESP,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t          r_state;
    logic            r_im_req;
    logic [31:0]     r_instr;
    logic            r_instr_valid;
    logic [XLEN-1:0] r_pc;
    logic            r_misaligned;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_plus_imm;
    logic [XLEN-1:0] w_next_pc;
    logic            w_done;
    logic            w_wd_expire;

    assign w_pc_plus4    = r_pc + XLEN'(4);
    assign w_pc_plus_imm = r_pc + imm;
    assign w_done        = (r_state == S_FETCH && im_gnt && im_rvalid) ||
                           (r_state == S_WAIT_RESP && im_rvalid);

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pcSel)
            3'd1:    w_next_pc = branch_taken ? w_pc_plus_imm : w_pc_plus4;
            3'd2:    w_next_pc = w_pc_plus_imm;
            3'd3:    w_next_pc = alu_result & ~XLEN'(1);
            3'd4:    w_next_pc = r_pc;
            default: w_next_pc = w_pc_plus4;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int              WD_W    = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd;
    logic            r_fetch_err;

    assign w_wd_expire = (r_state == S_FETCH || r_state == S_WAIT_RESP) && !w_done && (r_wd == WD_LAST);
    assign fetch_err   = r_fetch_err;

    // Held at zero outside the fetch states so every new fetch starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd        <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (r_state == S_BOOT || r_state == S_ISSUE) begin
                r_wd <= '0;
            end else if ((r_state == S_FETCH || r_state == S_WAIT_RESP) && !w_done) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_wd_expire) begin
                r_fetch_err <= 1'b1;
            end
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_im_req      <= 1'b0;
            r_instr       <= NOP;
            r_instr_valid <= 1'b0;
            r_pc          <= RESET_PC;
            r_misaligned  <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_im_req <= 1'b1;
                    r_state  <= S_FETCH;
                end
                S_FETCH: begin
                    if (im_gnt && im_rvalid) begin
                        r_instr       <= im_rdata;
                        r_instr_valid <= 1'b1;
                        r_im_req      <= 1'b0;
                        r_state       <= S_ISSUE;
                    end else if (w_wd_expire) begin
                        r_im_req <= 1'b0;
                        r_state  <= S_HALT;
                    end else if (im_gnt) begin
                        r_im_req <= 1'b0;
                        r_state  <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (im_rvalid) begin
                        r_instr       <= im_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end else if (w_wd_expire) begin
                        r_state <= S_HALT;
                    end
                end
                S_ISSUE: begin
                    if (commit) begin
                        r_instr_valid <= 1'b0;
                        // A misaligned target freezes pc at the offending instruction.
                        if (|w_next_pc[1:0]) begin
                            r_misaligned <= 1'b1;
                            r_state      <= S_HALT;
                        end else begin
                            r_pc     <= w_next_pc;
                            r_im_req <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    r_im_req      <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_im_req      <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= S_HALT;
                end
            endcase
        end
    end

    assign im_req      = r_im_req;
    assign im_addr     = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misaligned  = r_misaligned;
endmodule
